// File: rtl/encoder_8to3_if.sv
// ---------------------------------------------------------------------------
// encoder_8to3_if
//   Signal bundle between a request source and the 8-to-3 priority encoder.
//   master : drives en/in, observes the encoded result (request source / bench)
//   slave  : samples en/in, drives out/valid/multi (the encoder)
//   en     : encode enable
//   in     : request vector, one bit per source
//   out    : registered index of the winning request bit
//   valid  : registered "at least one request while enabled"
//   multi  : registered "two or more requests while enabled"
// ---------------------------------------------------------------------------
interface encoder_8to3_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = $clog2(IN_W)
);
    logic             en;
    logic [IN_W-1:0]  in;
    logic [OUT_W-1:0] out;
    logic             valid;
    logic             multi;

    modport master (
        output en,
        output in,
        input  out,
        input  valid,
        input  multi
    );

    modport slave (
        input  en,
        input  in,
        output out,
        output valid,
        output multi
    );
endinterface

// File: rtl/encoder_8to3.sv
// ---------------------------------------------------------------------------
// encoder_8to3
//   Registered priority encoder with enable. Turns an IN_W-bit request vector
//   into the index of its winning set bit, plus "any request" and
//   "more than one request" flags. One cycle of latency, full throughput,
//   no combinational path from inputs to outputs.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears all outputs at once
//   bus    : encoder_8to3_if.slave (en, in -> out, valid, multi)
//   MSB_PRIORITY = 1 : highest set bit wins; 0 : lowest set bit wins
// ---------------------------------------------------------------------------
module encoder_8to3 #(
    parameter int IN_W         = 8,
    parameter int OUT_W        = $clog2(IN_W),
    parameter bit MSB_PRIORITY = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    encoder_8to3_if.slave  bus
);

    logic [OUT_W-1:0] idx_c;
    logic             any_c;
    logic             multi_c;

    logic [OUT_W-1:0] out_q;
    logic             valid_q;
    logic             multi_q;

    // Priority scan: the last matching bit in loop order wins, so the loop
    // direction selects which end of the vector has priority.
    always_comb begin
        idx_c = '0;
        if (MSB_PRIORITY) begin
            for (int i = 0; i < IN_W; i++)
                if (bus.in[i]) idx_c = OUT_W'(i);
        end else begin
            for (int i = IN_W - 1; i >= 0; i--)
                if (bus.in[i]) idx_c = OUT_W'(i);
        end
    end

    // Clearing the lowest set bit leaves something behind only when at least
    // two bits were set, which gives popcount >= 2 without an adder tree.
    assign any_c   = |bus.in;
    assign multi_c = |(bus.in & (bus.in - IN_W'(1)));

    // The disabled branch never looks at bus.in, so unknown request lines
    // while en=0 cannot reach the registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else if (bus.en) begin
            out_q   <= idx_c;
            valid_q <= any_c;
            multi_q <= multi_c;
        end else begin
            out_q   <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
    assign bus.multi = multi_q;

endmodule

// File: tb/tb_encoder_8to3.sv
// ---------------------------------------------------------------------------
// tb_encoder_8to3
//   Drives two encoders (MSB and LSB priority) with identical stimulus.
//   Expected results are queued as each input is applied and checked one
//   clock later; reset behaviour is checked directly.
// ---------------------------------------------------------------------------
module tb_encoder_8to3;

    logic clk;
    logic rst_n;

    encoder_8to3_if #(.IN_W(8), .OUT_W(3)) bus_m ();
    encoder_8to3_if #(.IN_W(8), .OUT_W(3)) bus_l ();

    encoder_8to3 #(.IN_W(8), .OUT_W(3), .MSB_PRIORITY(1'b1)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_m.slave)
    );

    encoder_8to3 #(.IN_W(8), .OUT_W(3), .MSB_PRIORITY(1'b0)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] out_m;
        logic [2:0] out_l;
        logic       valid;
        logic       multi;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: highest set bit via ceil-log2, lowest set bit by isolating
    // it with v & -v, multi via population count.
    function automatic exp_t model(input logic e, input logic [7:0] v);
        exp_t        r;
        logic [8:0]  w;
        logic [7:0]  low;
        r = '0;
        if (e && v != 8'h00) begin
            w       = {1'b0, v} + 9'd1;
            r.out_m = 3'($clog2(w) - 1);
            low     = v & (~v + 8'd1);
            r.out_l = 3'($clog2(low));
            r.valid = 1'b1;
            r.multi = ($countones(v) >= 2);
        end
        return r;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, ".out_m"}, 32'(bus_m.out),   32'd0);
        chk({tag, ".out_l"}, 32'(bus_l.out),   32'd0);
        chk({tag, ".vld"},   32'(bus_m.valid | bus_l.valid), 32'd0);
        chk({tag, ".mul"},   32'(bus_m.multi | bus_l.multi), 32'd0);
    endtask

    // Apply one input, push its expectation, check it one edge later.
    task automatic drive(input string tag, input logic e, input logic [7:0] v);
        exp_t x;
        bus_m.en = e; bus_m.in = v;
        bus_l.en = e; bus_l.in = v;
        exp_q.push_back(model(e, v));
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        chk({tag, ".out_m"},   32'(bus_m.out),   32'(x.out_m));
        chk({tag, ".out_l"},   32'(bus_l.out),   32'(x.out_l));
        chk({tag, ".valid_m"}, 32'(bus_m.valid), 32'(x.valid));
        chk({tag, ".valid_l"}, 32'(bus_l.valid), 32'(x.valid));
        chk({tag, ".multi_m"}, 32'(bus_m.multi), 32'(x.multi));
        chk({tag, ".multi_l"}, 32'(bus_l.multi), 32'(x.multi));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] oh;

        // Reset held with active-looking inputs
        rst_n = 1'b0;
        bus_m.en = 1'b1; bus_m.in = 8'hFF;
        bus_l.en = 1'b1; bus_l.in = 8'hFF;
        #1;
        chk_zero("rst_imm");
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // One-hot sweep
        for (int i = 0; i < 8; i++) begin
            oh = 8'h01 << i;
            drive($sformatf("onehot%0d", i), 1'b1, oh);
        end
        // Sanity on the model for the spec example
        chk("model84_m", 32'(model(1'b1, 8'h84).out_m), 32'd7);
        chk("model84_l", 32'(model(1'b1, 8'h84).out_l), 32'd2);

        // Multi-hot
        drive("multi84", 1'b1, 8'h84);
        drive("multiFF", 1'b1, 8'hFF);
        drive("multi06", 1'b1, 8'h06);

        // Enable gating, including unknown request lines
        drive("dis40", 1'b0, 8'h40);
        drive("disX",  1'b0, 8'hxx);
        drive("en40",  1'b1, 8'h40);

        // Zero vs bit 0
        drive("zero", 1'b1, 8'h00);
        drive("bit0", 1'b1, 8'h01);

        // Async reset mid-stream
        drive("pre_rst", 1'b1, 8'hA0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(posedge clk);
        #1;
        chk_zero("rst_mid_hold");
        @(negedge clk);
        rst_n = 1'b1;
        drive("post_rst", 1'b1, 8'h30);

        // Back-to-back random stream
        for (int i = 0; i < 40; i++)
            drive($sformatf("rnd%0d", i), ($urandom_range(0, 3) != 0), 8'($urandom));

        if (exp_q.size() != 0) chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
